// File: rtl/bloom_filter_writer.sv
// bloom_filter_writer: hashes 72-bit flow keys with the lookup-path mix and sets the matching bit
// in the 1-bit filter BRAM; also sweeps the whole filter to zero on a clear request.
module bloom_filter_writer #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ins_valid_i,
    output logic              ins_ready_o,
    input  logic [71:0]       ins_key_i,
    input  logic              clr_valid_i,
    output logic              clr_ready_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wdata_o,
    output logic              done_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  insert_count_o
);
    typedef enum logic [3:0] {IDLE, C1, C2, C3, C4, C5, C6, WRITE, CLEAR} state_t;
    state_t state_q;
    logic [31:0] a_q, b_q, c_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] c1_d, a1_d, b1_d, a2_d, b2_d;
    logic [ADDR_W-1:0] h_d;
    assign c1_d = (c_q ^ b_q) - {b_q[17:0], b_q[31:18]};
    assign a1_d = (a_q ^ c_q) - {c_q[20:0], c_q[31:21]};
    assign b1_d = (b_q ^ a_q) - {a_q[6:0], a_q[31:7]};
    assign a2_d = (a_q ^ c_q) - {c_q[27:0], c_q[31:28]};
    assign b2_d = (b_q ^ a_q) - {a_q[17:0], a_q[31:18]};
    // Only the address bits of the final stage matter; low bits of a subtraction depend only on low bits.
    assign h_d  = (c_q[ADDR_W-1:0] ^ b_q[ADDR_W-1:0]) - b_q[ADDR_W+7:8];
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_valid_i) begin
                        state_q <= CLEAR;
                        addr_q  <= '0;
                    end else if (ins_valid_i) begin
                        a_q     <= 32'hdeadbef8 + ins_key_i[71:40];
                        b_q     <= 32'hdeadbef1 + ins_key_i[39:8];
                        c_q     <= 32'hdeadbef8 + {24'b0, ins_key_i[7:0]};
                        state_q <= C1;
                    end
                end
                C1: begin
                    c_q     <= c1_d;
                    state_q <= C2;
                end
                C2: begin
                    a_q     <= a1_d;
                    state_q <= C3;
                end
                C3: begin
                    b_q     <= b1_d;
                    state_q <= C4;
                end
                C4: begin
                    a_q     <= a2_d;
                    state_q <= C5;
                end
                C5: begin
                    b_q     <= b2_d;
                    state_q <= C6;
                end
                C6: begin
                    addr_q  <= h_d;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (mem_gnt_i) begin
                        state_q <= IDLE;
                        cnt_q   <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                CLEAR: begin
                    if (mem_gnt_i) begin
                        addr_q <= addr_q + 1'b1;
                        if (&addr_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_req_o      = (state_q == WRITE) || (state_q == CLEAR);
    assign mem_we_o       = mem_req_o & mem_gnt_i;
    assign mem_wdata_o    = (state_q == WRITE);
    assign mem_addr_o     = addr_q;
    assign done_o         = mem_we_o & (mem_wdata_o | (&addr_q));
    assign busy_o         = (state_q != IDLE);
    assign clr_ready_o    = (state_q == IDLE);
    assign ins_ready_o    = clr_ready_o & ~clr_valid_i;
    assign insert_count_o = cnt_q;
endmodule
